// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_c pulses
// combinationally on the byte that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned LANE_W = WORD_W - BYTE_W;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LANE_W-1:0] lanes_q, lanes_d;

  // Final byte is not stored: it is forwarded straight into the top lane.
  assign word_valid_c = byte_valid_i && !clear_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_i, lanes_q};

  // Next lane contents and byte index.
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clear_i) begin
      idx_d   = '0;
      lanes_d = '0;
    end else if (byte_valid_i) begin
      for (int k = 0; k < int'(BYTES_PER_WORD) - 1; k++) begin
        if (idx_q == IDX_W'(k)) lanes_d[k*BYTE_W +: BYTE_W] = byte_i;
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Lane and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a word-count header and byte
// payload from the host link, writes words to IMEM and releases core reset
// once the image is in place. Optional trailing XOR checksum is enabled by
// defining IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e ST_TAIL = ST_CSUM;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              xfer;
  logic [HDR_W-1:0]  n_hdr;
  logic              oversize;
  logic              last_word;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign s_ready   = (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign xfer      = s_valid && s_ready;
  assign n_hdr     = {s_data, n_q[BYTE_W-1:0]};
  assign oversize  = 32'(n_hdr) > CAP;
  assign last_word = (32'(cnt_q) + 32'd1) == 32'(n_q);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q != ST_DATA),
    .byte_valid_i (xfer),
    .byte_i       (s_data),
    .word_valid_c (word_valid),
    .word_c       (word)
  );

  // Frame parser: next state, counters, memory port and status outputs.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_HDR_LO: if (xfer) begin
        n_d     = {n_q[HDR_W-1:BYTE_W], s_data};
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = s_data;
`endif
        state_d = ST_HDR_HI;
      end
      ST_HDR_HI: if (xfer) begin
        n_d   = n_hdr;
        cnt_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d = csum_q ^ s_data;
`endif
        if (oversize)           state_d = ST_ERROR;
        else if (n_hdr == '0)   state_d = ST_TAIL;
        else                    state_d = ST_DATA;
      end
      ST_DATA: if (xfer) begin
`ifdef IMEM_LOADER_CSUM_EN
        csum_d = csum_q ^ s_data;
`endif
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = word;
          cnt_d       = cnt_q + CNT_W'(1);
          if (last_word) state_d = ST_TAIL;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: if (xfer) begin
        state_d = (s_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: if (reload) state_d = ST_HDR_LO;
      default: state_d = ST_HDR_LO;
    endcase

    // Status lags state entry by one cycle but drops on the reload edge.
    done_d     = (state_q == ST_DONE) && (state_d == ST_DONE);
    core_rst_d = !done_d;
    error_d    = (state_q == ST_ERROR) && (state_d == ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HDR_LO;
      n_q         <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2, capacity 4 words).
module tb_imem_loader;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CAP    = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [15:0]      n;
    logic [5:0][31:0] w;
    logic [7:0]       cx;
    bit               gaps;
    bit               exp_err;
    int               exp_wr;
  } vec_t;

  vec_t tbl[6];

  // Capture every IMEM write the DUT issues.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(32'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},   32'(s_ready),   32'd1);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_core_rst"},  32'(core_rst),  32'd1);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
  endtask

  // Streams tx_q; returns at the falling edge after the last accepted byte.
  task automatic drive(input bit gaps, input bit rr, output int sent);
    int  i = 0;
    int  guard = 0;
    bit  broke = 1'b0;
    while (i < tx_q.size() && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!s_ready) begin
        broke = 1'b1;
        break;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = tx_q[i];
        i++;
      end
      reload = rr && ($urandom_range(0, 7) == 0);
    end
    if (guard >= 400) chk("drive_timeout", 32'(guard), 32'd0);
    if (!broke) @(negedge clk);
    s_valid = 1'b0;
    reload  = 1'b0;
    sent    = i;
  endtask

  task automatic run_frame(input logic [15:0] n, input logic [5:0][31:0] w, input logic [7:0] cx,
                           input bit gaps, input bit rr, input bit exp_err, input int exp_wr,
                           input string tag);
    logic [7:0] x;
    int  sent;
    int  exp_sent;
    bit  big;
    big = (32'(n) > CAP);
    tx_q.delete();
    wa_q.delete();
    wd_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    if (big) begin
      for (int k = 0; k < 4; k++) tx_q.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < int'(n); i++)
        for (int b = 0; b < 4; b++) tx_q.push_back(8'(w[i] >> (8 * b)));
      if (CSUM_ON) begin
        x = 8'h00;
        foreach (tx_q[j]) x = x ^ tx_q[j];
        tx_q.push_back(x ^ cx);
      end
    end
    exp_sent = big ? 2 : tx_q.size();
    drive(gaps, rr, sent);
    chk({tag, "_sent"}, 32'(sent), 32'(exp_sent));
    chk({tag, "_c1_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_c1_done"}, 32'(done), 32'd0);
    chk({tag, "_c1_error"}, 32'(error), 32'd0);
    chk({tag, "_c1_mem_we"}, 32'(mem_we), 32'(!CSUM_ON && !big && n != 16'd0));
    @(negedge clk);
    chk({tag, "_c2_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_c2_core_rst"}, 32'(core_rst), 32'(exp_err));
    chk({tag, "_c2_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_c2_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(exp_wr));
    for (int i = 0; i < exp_wr && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[i], 32'(i));
      chk({tag, "_data"}, wd_q[i], w[i]);
    end
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_rl_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_rl_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_rl_done"}, 32'(done), 32'd0);
    chk({tag, "_rl_error"}, 32'(error), 32'd0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0][31:0] w;
    logic [15:0]      n;
    logic [7:0]       cx;
    bit               e;

    tbl[0] = '{n: 16'd2, w: '0, cx: 8'h00, gaps: 1'b0, exp_err: 1'b0, exp_wr: 2};
    tbl[0].w[0] = 32'h0000_0013;
    tbl[0].w[1] = 32'h0050_00B3;
    tbl[1] = '{n: 16'd0, w: '0, cx: 8'h00, gaps: 1'b0, exp_err: 1'b0, exp_wr: 0};
    tbl[2] = '{n: 16'd5, w: '0, cx: 8'h00, gaps: 1'b0, exp_err: 1'b1, exp_wr: 0};
    tbl[3] = '{n: 16'd1, w: '0, cx: 8'h05, gaps: 1'b0, exp_err: CSUM_ON, exp_wr: 1};
    tbl[3].w[0] = 32'h0403_0201;
    tbl[4] = '{n: 16'd4, w: '0, cx: 8'h00, gaps: 1'b1, exp_err: 1'b0, exp_wr: 4};
    tbl[4].w[0] = 32'hDEAD_BEEF;
    tbl[4].w[1] = 32'h1234_5678;
    tbl[4].w[2] = 32'hCAFE_F00D;
    tbl[4].w[3] = 32'h8000_0001;
    tbl[5] = '{n: 16'd3, w: '0, cx: 8'h00, gaps: 1'b1, exp_err: 1'b0, exp_wr: 3};
    tbl[5].w[0] = 32'hA5A5_5A5A;
    tbl[5].w[1] = 32'h0F0F_F0F0;
    tbl[5].w[2] = 32'hFFFF_FFFF;

    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    reload  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++)
      run_frame(tbl[t].n, tbl[t].w, tbl[t].cx, tbl[t].gaps, 1'b0, tbl[t].exp_err, tbl[t].exp_wr,
                $sformatf("vec%0d", t));

    // Reset mid-load: one word written, then two bytes of the next word.
    wa_q.delete();
    wd_q.delete();
    put_byte(8'h02); put_byte(8'h00);
    put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
    put_byte(8'h11); put_byte(8'h22);
    chk("mid_wdata_before", mem_wdata, 32'hDDCC_BBAA);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid");
    chk("mid_nwr", 32'(wa_q.size()), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    w = '0;
    w[0] = 32'h0123_4567;
    w[1] = 32'h89AB_CDEF;
    run_frame(16'd2, w, 8'h00, 1'b1, 1'b0, 1'b0, 2, "post_rst");

    // Randomized frames against the reference expectations.
    for (int r = 0; r < 40; r++) begin
      n  = 16'($urandom_range(0, 6));
      for (int i = 0; i < 6; i++) w[i] = $urandom;
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      e  = (32'(n) > CAP) || (CSUM_ON && cx != 8'h00);
      run_frame(n, w, cx, 1'b1, 1'b1, e, (32'(n) > CAP) ? 0 : int'(n), $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
